// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC frame packager.
package adc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StCsum,
        StEnd
    } state_t;

    localparam logic [7:0] DEFAULT_START_BYTE = 8'h00;
    localparam logic [7:0] DEFAULT_END_BYTE   = 8'hFF;

    function automatic int unsigned bps(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/adc_snapshot_buffer.sv
// Working/pending sample registers. The working copy only changes between frames,
// so the frame being serialised is never disturbed.
module adc_snapshot_buffer
    import adc_pkg::*;
#(
    parameter int unsigned WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_capture,
    input  logic             i_promote,
    input  logic             i_busy,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_working,
    output logic             o_pending_full,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_working;
    logic [WIDTH-1:0] r_pending;
    logic             r_pend_full;
    logic             r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_working   <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_promote) begin
                // End-of-frame handoff: a strobe here never overruns.
                if (r_pend_full) begin
                    r_working <= r_pending;
                    if (i_capture) begin
                        r_pending <= i_data;
                    end else begin
                        r_pend_full <= 1'b0;
                    end
                end else if (i_capture) begin
                    r_working <= i_data;
                end
            end else if (i_capture) begin
                if (!i_busy) begin
                    r_working <= i_data;
                end else if (!r_pend_full) begin
                    r_pending   <= i_data;
                    r_pend_full <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign o_working      = r_working;
    assign o_pending_full = r_pend_full;
    assign o_overrun      = r_overrun;

endmodule

// File: rtl/adc_frame_packager.sv
// Serialises N ADC channel snapshots into a start/payload/checksum/end byte frame
// over a valid/ready byte stream.
module adc_frame_packager
    import adc_pkg::*;
#(
    parameter int unsigned ADC_DATA_WIDTH = 16,
    parameter int unsigned ADC_COUNT      = 6,
    parameter logic [7:0]  START_BYTE     = DEFAULT_START_BYTE,
    parameter logic [7:0]  END_BYTE       = DEFAULT_END_BYTE,
    parameter bit          CHECKSUM_EN    = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADC_COUNT*ADC_DATA_WIDTH-1:0] data_adc,
    input  logic                                write_enable,
    input  logic                                tx_ready,
    output logic [7:0]                          data_out,
    output logic                                tx_valid,
    output logic                                busy,
    output logic                                frame_done,
    output logic                                overrun
);

    localparam int unsigned BPS   = bps(ADC_DATA_WIDTH);
    localparam int unsigned TOT_W = ADC_COUNT * ADC_DATA_WIDTH;
    localparam int unsigned CH_W  = (ADC_COUNT > 1) ? $clog2(ADC_COUNT) : 1;
    localparam int unsigned BY_W  = (BPS > 1) ? $clog2(BPS) : 1;
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(ADC_COUNT - 1);
    localparam logic [BY_W-1:0] TOP_BYTE = BY_W'(BPS - 1);

    state_t            r_state;
    state_t            w_state_d;
    logic [CH_W-1:0]   r_ch, w_ch_d;
    logic [BY_W-1:0]   r_byte, w_byte_d;
    logic [7:0]        r_csum, w_csum_d;
    logic [7:0]        r_data_out, w_data_d;
    logic              r_tx_valid;
    logic              r_busy;
    logic              w_xfer;
    logic              w_promote;
    logic              w_frame_done;
    logic              w_pend_full;
    logic              w_overrun;
    logic [TOT_W-1:0]  w_working;

    function automatic logic [7:0] payload_byte(input logic [TOT_W-1:0] words,
                                                input logic [CH_W-1:0]  ch,
                                                input logic [BY_W-1:0]  by);
        logic [TOT_W-1:0] shifted;
        shifted = words >> (int'(ch) * int'(ADC_DATA_WIDTH) + int'(by) * 8);
        return shifted[7:0];
    endfunction

    adc_snapshot_buffer #(
        .WIDTH (TOT_W)
    ) u_snapshot (
        .clk            (clk),
        .rst            (rst),
        .i_capture      (write_enable),
        .i_promote      (w_promote),
        .i_busy         (r_state != StIdle),
        .i_data         (data_adc),
        .o_working      (w_working),
        .o_pending_full (w_pend_full),
        .o_overrun      (w_overrun)
    );

    assign w_xfer = r_tx_valid && tx_ready;

    always_comb begin
        w_state_d    = r_state;
        w_ch_d       = r_ch;
        w_byte_d     = r_byte;
        w_csum_d     = r_csum;
        w_promote    = 1'b0;
        w_frame_done = 1'b0;
        w_data_d     = 8'h00;
        unique case (r_state)
            StIdle: if (write_enable) w_state_d = StStart;
            StStart: begin
                if (w_xfer) begin
                    w_state_d = StData;
                    w_ch_d    = '0;
                    w_byte_d  = TOP_BYTE;
                end
            end
            StData: begin
                if (w_xfer) begin
                    w_csum_d = r_csum ^ r_data_out;
                    if (r_byte != '0) begin
                        w_byte_d = r_byte - BY_W'(1);
                    end else if (r_ch != LAST_CH) begin
                        w_byte_d = TOP_BYTE;
                        w_ch_d   = r_ch + CH_W'(1);
                    end else begin
                        w_state_d = CHECKSUM_EN ? StCsum : StEnd;
                    end
                end
            end
            StCsum: if (w_xfer) w_state_d = StEnd;
            StEnd: begin
                if (w_xfer) begin
                    w_promote    = 1'b1;
                    w_frame_done = 1'b1;
                    w_state_d    = (w_pend_full || write_enable) ? StStart : StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (w_state_d == StStart && r_state != StStart) begin
            w_csum_d = '0;
        end

        // Output byte is precomputed from next state so data_out/tx_valid stay registered.
        unique case (w_state_d)
            StStart: w_data_d = START_BYTE;
            StData:  w_data_d = payload_byte(w_working, w_ch_d, w_byte_d);
            StCsum:  w_data_d = w_csum_d;
            StEnd:   w_data_d = END_BYTE;
            default: w_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_ch       <= '0;
            r_byte     <= '0;
            r_csum     <= '0;
            r_data_out <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_ch       <= w_ch_d;
            r_byte     <= w_byte_d;
            r_csum     <= w_csum_d;
            r_data_out <= w_data_d;
            r_tx_valid <= (w_state_d != StIdle);
            r_busy     <= (w_state_d != StIdle);
        end
    end

    assign data_out   = r_data_out;
    assign tx_valid   = r_tx_valid;
    assign busy       = r_busy;
    assign frame_done = w_frame_done;
    assign overrun    = w_overrun;

endmodule
